// File: rtl/cdb_arbiter_pkg.sv
// CDB shared types: tag/data widths, the reserved
// "no producer" tag and the broadcast bundle.
package cdb_arbiter_pkg;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  function automatic logic tag_is_none(
    input logic [TAG_W-1:0] t
  );
    return t == TAG_NONE;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotate-priority picker: first eligible index
// starting at ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [W:0] j;

  // scan ptr, ptr+1, ... with wrap; first hit wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr_i} + (W+1)'(k);
      if (j >= (W+1)'(N)) begin
        j = j - (W+1)'(N);
      end
      if (!any_o && elig_i[j[W-1:0]]) begin
        any_o             = 1'b1;
        idx_o             = j[W-1:0];
        grant_o[j[W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one result per cycle,
// registered {tag, data} broadcast, sticky tag-0 error.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      err_tag0
);

  import cdb_arbiter_pkg::*;

  localparam logic [TAG_W-1:0] NONE =
    TAG_W'(TAG_NONE);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] tag0_hit;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              err_q, err_d;

  // tag 0 never competes; flush removes everyone
  always_comb begin
    elig     = '0;
    tag0_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tag0_hit[i] = req_valid[i] &&
        (req_tag[i*TAG_W +: TAG_W] == NONE);
      elig[i] = req_valid[i] && !tag0_hit[i] && !flush;
    end
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (SRC_W)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign req_grant = pick_grant;

  // next broadcast, pointer advance and sticky error
  always_comb begin
    vld_d  = pick_any;
    tag_d  = tag_q;
    data_d = data_q;
    src_d  = src_q;
    ptr_d  = ptr_q;
    err_d  = err_q | (|tag0_hit);
    if (pick_any) begin
      tag_d  = req_tag[int'(pick_idx)*TAG_W +: TAG_W];
      data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
      src_d  = pick_idx;
      if (pick_idx == SRC_W'(NUM_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + SRC_W'(1);
      end
    end
  end

  // CDB registers; async reset drops any broadcast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      src_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      src_q  <= src_d;
      err_q  <= err_d;
    end
  end

  assign cdb_valid = vld_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_src   = src_q;
  assign err_tag0  = err_q;

endmodule
